mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single-port data memory between the pipeline MEM stage (CPU port) and the UART DMA engine (DMA port).
- Sits between the MEM-stage address/data wires and the data memory; replaces the direct MEM-to-memory hookup.
- Owns the memory access sequencing (fixed-latency access FSM).
- Generates the CPU stall that the hazard unit ORs into its PC/IF_ID write-enable freeze.

Parameters:
- MEM_LAT, 1: memory access latency in cycles; strobes are held this long; legal range 1..15.
- STARVE_LIM, 4: consecutive CPU wins while DMA waits before DMA is forced to win; legal range 1..15.

Ports:
- sysclk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request, held until cpu_ack
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  write data
- cpu_rdata  out  32  read data, valid while cpu_ack
- cpu_ack  out  1  one-cycle completion pulse
- cpu_err  out  1  misaligned-access flag, valid while cpu_ack
- cpu_stall  out  1  cpu_req & ~cpu_ack, combinational
- dma_req, dma_we, dma_addr[32], dma_wdata[32]  in  same rules as CPU port
- dma_rdata[32], dma_ack, dma_err  out  same rules as CPU port
- mem_rd  out  1  memory read strobe
- mem_wr  out  1  memory write strobe
- mem_addr  out  32  latched address
- mem_wdata  out  32  latched write data
- mem_rdata  in  32  memory read data, valid in last ACCESS cycle
- busy  out  1  FSM not in IDLE

Behaviour:
- States:
  - IDLE, ACCESS, RESP.
  - Registers: owner (0=CPU, 1=DMA), lat_cnt (4b), starve_cnt (4b), err_r, rdata_r, addr_r, wdata_r, we_r.
- Reset (sync, overrides everything, including mid-access):
  - state=IDLE; all acks, errs, strobes and busy = 0.
  - rdata outputs = 0; mem_addr = 0; mem_wdata = 0.
  - starve_cnt = 0; lat_cnt = 0.
  - An in-flight access is abandoned with no ack.
- IDLE:
  - If no request, stay in IDLE.
  - Otherwise pick a winner:
    - DMA wins if dma_req & (~cpu_req | starve_cnt == STARVE_LIM).
    - Else CPU wins.
  - Latch the winner's addr, we and wdata; set owner.
  - starve_cnt: incremented (saturating at STARVE_LIM) when CPU wins while dma_req is high; cleared when DMA wins; unchanged otherwise.
  - If addr[1:0] != 0: set err_r=1, go to RESP; no strobe is issued, rdata=0.
  - Else: err_r=0, lat_cnt=0, go to ACCESS.
- ACCESS:
  - mem_rd = ~we_r and mem_wr = we_r, both held high for exactly MEM_LAT cycles.
  - mem_addr and mem_wdata are stable throughout.
  - When lat_cnt == MEM_LAT-1: capture mem_rdata into rdata_r (reads only; writes capture 0), go to RESP.
  - Otherwise lat_cnt increments.
- RESP:
  - Owner's ack = 1 for exactly one cycle; owner's rdata/err driven from rdata_r/err_r.
  - Non-owner's ack = 0; its rdata = 0.
  - Next state is always IDLE.
- Latency:
  - Request sampled in IDLE at edge k: ACCESS occupies cycles k+1..k+MEM_LAT; ack is in cycle k+MEM_LAT+1.
  - Misaligned access: ack in cycle k+1.
  - Minimum spacing between grants is MEM_LAT+2 cycles.
- Handshake:
  - Requester holds req and its fields stable until ack.
  - A requester that still asserts req in the cycle after its ack is treated as a new request.
  - A req dropped before ack is a protocol violation; the access still completes and ack is still pulsed.
- Simultaneous requests:
  - CPU wins unless the starvation limit forces DMA.
  - The loser's req is held and it wins no later than after STARVE_LIM further CPU grants.
- Strobes:
  - mem_rd and mem_wr are never high together.
  - Both are low outside ACCESS.
- cpu_stall is combinational; it is high during the entire wait, including while DMA owns the bus.

Test Plan:
- MEM_LAT=2, single CPU read of 0x0000_0010 with mem_rdata=0xDEAD_BEEF → mem_rd high 2 cycles; cpu_ack with cpu_rdata=0xDEAD_BEEF 3 cycles after req sampled; cpu_stall high until then; dma_ack stays 0.
- CPU write of 0x1234_5678 to 0x20 → mem_wr high MEM_LAT cycles with mem_addr=0x20 and mem_wdata=0x1234_5678; mem_rd stays 0; cpu_ack pulse, cpu_err=0.
- Misaligned CPU read of 0x0000_0013 → no strobe; cpu_ack plus cpu_err=1 one cycle after sampling; cpu_rdata=0.
- CPU and DMA both continuously requesting, STARVE_LIM=4 → grant sequence CPU,CPU,CPU,CPU,DMA, repeating; starve_cnt clears on the DMA grant.
- Reset asserted during the 2nd ACCESS cycle of a DMA write → strobes drop next edge; no dma_ack; busy=0; after reset release, a pending CPU request is granted first.
- DMA alone, back-to-back reads with req held through ack → second access begins in the IDLE cycle following RESP; acks are spaced MEM_LAT+2 cycles apart.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Shares the single-port data memory between the CPU MEM stage and the UART DMA engine.
// A fixed-latency access FSM sequences each grant and produces the CPU stall for the hazard unit.
module mem_bus_arbiter #(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_LIM = 4
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ack,
  output logic        cpu_err,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic [31:0] dma_rdata,
  output logic        dma_ack,
  output logic        dma_err,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam logic [3:0] LAT_LAST   = 4'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIM);

  state_t      state;
  logic        owner;
  logic [3:0]  lat_cnt;
  logic [3:0]  starve_cnt;
  logic        err_r;
  logic [31:0] rdata_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic        we_r;

  logic        dma_win;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        misaligned;

  // DMA only beats a simultaneous CPU request once the CPU has starved it STARVE_LIM times
  always_comb begin
    dma_win    = dma_req & (~cpu_req | (starve_cnt == STARVE_MAX));
    sel_we     = dma_win ? dma_we    : cpu_we;
    sel_addr   = dma_win ? dma_addr  : cpu_addr;
    sel_wdata  = dma_win ? dma_wdata : cpu_wdata;
    misaligned = (sel_addr[1:0] != 2'b00);
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      lat_cnt    <= 4'd0;
      starve_cnt <= 4'd0;
      err_r      <= 1'b0;
      rdata_r    <= 32'd0;
      addr_r     <= 32'd0;
      wdata_r    <= 32'd0;
      we_r       <= 1'b0;
      cpu_ack    <= 1'b0;
      dma_ack    <= 1'b0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      dma_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req | dma_req) begin
            owner   <= dma_win;
            addr_r  <= sel_addr;
            we_r    <= sel_we;
            wdata_r <= sel_wdata;
            busy    <= 1'b1;
            if (dma_win) begin
              starve_cnt <= 4'd0;
            end else if (dma_req && (starve_cnt != STARVE_MAX)) begin
              starve_cnt <= starve_cnt + 4'd1;
            end
            // Misaligned accesses never touch memory; they answer straight away with an error
            if (misaligned) begin
              err_r   <= 1'b1;
              rdata_r <= 32'd0;
              cpu_ack <= ~dma_win;
              dma_ack <= dma_win;
              state   <= RESP;
            end else begin
              err_r   <= 1'b0;
              lat_cnt <= 4'd0;
              mem_rd  <= ~sel_we;
              mem_wr  <= sel_we;
              state   <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (lat_cnt == LAT_LAST) begin
            rdata_r <= we_r ? 32'd0 : mem_rdata;
            mem_rd  <= 1'b0;
            mem_wr  <= 1'b0;
            cpu_ack <= ~owner;
            dma_ack <= owner;
            state   <= RESP;
          end else begin
            lat_cnt <= lat_cnt + 4'd1;
          end
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          mem_rd <= 1'b0;
          mem_wr <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign cpu_rdata = cpu_ack ? rdata_r : 32'd0;
  assign dma_rdata = dma_ack ? rdata_r : 32'd0;
  assign cpu_err   = cpu_ack & err_r;
  assign dma_err   = dma_ack & err_r;
  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;

  // Stall covers the whole wait, including cycles where DMA holds the bus
  assign cpu_stall = cpu_req & ~cpu_ack;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with MEM_LAT=2, STARVE_LIM=4: per-cycle vector table
// followed by hand-written starvation and mid-access reset sequences.
module tb_mem_bus_arbiter;

  logic        sysclk;
  logic        reset;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ack;
  logic        cpu_err;
  logic        cpu_stall;
  logic        dma_req;
  logic        dma_we;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic [31:0] dma_rdata;
  logic        dma_ack;
  logic        dma_err;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;

  int checks = 0;
  int errors = 0;

  mem_bus_arbiter #(
    .MEM_LAT(2),
    .STARVE_LIM(4)
  ) dut (
    .sysclk(sysclk),
    .reset(reset),
    .cpu_req(cpu_req),
    .cpu_we(cpu_we),
    .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .cpu_ack(cpu_ack),
    .cpu_err(cpu_err),
    .cpu_stall(cpu_stall),
    .dma_req(dma_req),
    .dma_we(dma_we),
    .dma_addr(dma_addr),
    .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata),
    .dma_ack(dma_ack),
    .dma_err(dma_err),
    .mem_rd(mem_rd),
    .mem_wr(mem_wr),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .busy(busy)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  // flags = {cpu_ack, cpu_err, dma_ack, dma_err, mem_rd, mem_wr, busy, cpu_stall}
  typedef struct {
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        dma_req;
    logic        dma_we;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic [31:0] mem_rdata;
    logic [7:0]  flags;
    logic [31:0] cpu_rdata;
    logic [31:0] dma_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
  } vec_t;

  vec_t vecs[$];

  task automatic applyStimulus(input logic c_req, input logic c_we, input logic [31:0] c_addr,
                               input logic [31:0] c_wdata, input logic d_req, input logic d_we,
                               input logic [31:0] d_addr, input logic [31:0] d_wdata,
                               input logic [31:0] m_rdata);
    cpu_req   = c_req;
    cpu_we    = c_we;
    cpu_addr  = c_addr;
    cpu_wdata = c_wdata;
    dma_req   = d_req;
    dma_we    = d_we;
    dma_addr  = d_addr;
    dma_wdata = d_wdata;
    mem_rdata = m_rdata;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge sysclk);
    @(negedge sysclk);
  endtask

  initial begin
    int grants;
    int cyc;
    bit seen;
    logic [7:0] act_flags;

    // CPU aligned read of 0x10
    vecs.push_back(vec_t'{1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'hDEADBEEF, 8'b0000_0001, 32'h0, 32'h0, 32'h0, 32'h0});
    vecs.push_back(vec_t'{1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'hDEADBEEF, 8'b0000_1011, 32'h0, 32'h0, 32'h10, 32'h0});
    vecs.push_back(vec_t'{1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'hDEADBEEF, 8'b0000_1011, 32'h0, 32'h0, 32'h10, 32'h0});
    vecs.push_back(vec_t'{1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'hDEADBEEF, 8'b1000_0010, 32'hDEADBEEF, 32'h0, 32'h10, 32'h0});
    vecs.push_back(vec_t'{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'hDEADBEEF, 8'b0000_0000, 32'h0, 32'h0, 32'h10, 32'h0});
    // CPU write of 0x12345678 to 0x20
    vecs.push_back(vec_t'{1'b1, 1'b1, 32'h20, 32'h12345678, 1'b0, 1'b0, 32'h0, 32'h0, 32'hDEADBEEF, 8'b0000_0001, 32'h0, 32'h0, 32'h10, 32'h0});
    vecs.push_back(vec_t'{1'b1, 1'b1, 32'h20, 32'h12345678, 1'b0, 1'b0, 32'h0, 32'h0, 32'hDEADBEEF, 8'b0000_0111, 32'h0, 32'h0, 32'h20, 32'h12345678});
    vecs.push_back(vec_t'{1'b1, 1'b1, 32'h20, 32'h12345678, 1'b0, 1'b0, 32'h0, 32'h0, 32'hDEADBEEF, 8'b0000_0111, 32'h0, 32'h0, 32'h20, 32'h12345678});
    vecs.push_back(vec_t'{1'b1, 1'b1, 32'h20, 32'h12345678, 1'b0, 1'b0, 32'h0, 32'h0, 32'hDEADBEEF, 8'b1000_0010, 32'h0, 32'h0, 32'h20, 32'h12345678});
    vecs.push_back(vec_t'{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'hDEADBEEF, 8'b0000_0000, 32'h0, 32'h0, 32'h20, 32'h12345678});
    // CPU misaligned read of 0x13
    vecs.push_back(vec_t'{1'b1, 1'b0, 32'h13, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'hDEADBEEF, 8'b0000_0001, 32'h0, 32'h0, 32'h20, 32'h12345678});
    vecs.push_back(vec_t'{1'b1, 1'b0, 32'h13, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'hDEADBEEF, 8'b1100_0010, 32'h0, 32'h0, 32'h13, 32'h0});
    vecs.push_back(vec_t'{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'hDEADBEEF, 8'b0000_0000, 32'h0, 32'h0, 32'h13, 32'h0});
    // DMA back-to-back reads of 0x40, req held through the first ack
    vecs.push_back(vec_t'{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, 32'hCAFEF00D, 8'b0000_0000, 32'h0, 32'h0, 32'h13, 32'h0});
    vecs.push_back(vec_t'{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, 32'hCAFEF00D, 8'b0000_1010, 32'h0, 32'h0, 32'h40, 32'h0});
    vecs.push_back(vec_t'{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, 32'hCAFEF00D, 8'b0000_1010, 32'h0, 32'h0, 32'h40, 32'h0});
    vecs.push_back(vec_t'{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, 32'hCAFEF00D, 8'b0010_0010, 32'h0, 32'hCAFEF00D, 32'h40, 32'h0});
    vecs.push_back(vec_t'{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, 32'hCAFEF00D, 8'b0000_0000, 32'h0, 32'h0, 32'h40, 32'h0});
    vecs.push_back(vec_t'{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, 32'h0BADCAFE, 8'b0000_1010, 32'h0, 32'h0, 32'h40, 32'h0});
    vecs.push_back(vec_t'{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, 32'h0BADCAFE, 8'b0000_1010, 32'h0, 32'h0, 32'h40, 32'h0});
    vecs.push_back(vec_t'{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, 32'h0BADCAFE, 8'b0010_0010, 32'h0, 32'h0BADCAFE, 32'h40, 32'h0});
    vecs.push_back(vec_t'{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0BADCAFE, 8'b0000_0000, 32'h0, 32'h0, 32'h40, 32'h0});
    // DMA misaligned write to 0x42
    vecs.push_back(vec_t'{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h42, 32'h77, 32'h0BADCAFE, 8'b0000_0000, 32'h0, 32'h0, 32'h40, 32'h0});
    vecs.push_back(vec_t'{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h42, 32'h77, 32'h0BADCAFE, 8'b0011_0010, 32'h0, 32'h0, 32'h42, 32'h77});
    vecs.push_back(vec_t'{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0BADCAFE, 8'b0000_0000, 32'h0, 32'h0, 32'h42, 32'h77});

    // Reset and check the cleared state
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    repeat (2) @(posedge sysclk);
    @(negedge sysclk);
    reset = 1'b0;
    #1;
    checkOutput("reset_cpu_ack",   32'(cpu_ack),   32'd0);
    checkOutput("reset_dma_ack",   32'(dma_ack),   32'd0);
    checkOutput("reset_cpu_err",   32'(cpu_err),   32'd0);
    checkOutput("reset_dma_err",   32'(dma_err),   32'd0);
    checkOutput("reset_mem_rd",    32'(mem_rd),    32'd0);
    checkOutput("reset_mem_wr",    32'(mem_wr),    32'd0);
    checkOutput("reset_busy",      32'(busy),      32'd0);
    checkOutput("reset_cpu_rdata", cpu_rdata,      32'd0);
    checkOutput("reset_dma_rdata", dma_rdata,      32'd0);
    checkOutput("reset_mem_addr",  mem_addr,       32'd0);
    checkOutput("reset_mem_wdata", mem_wdata,      32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].cpu_req, vecs[i].cpu_we, vecs[i].cpu_addr, vecs[i].cpu_wdata,
                    vecs[i].dma_req, vecs[i].dma_we, vecs[i].dma_addr, vecs[i].dma_wdata,
                    vecs[i].mem_rdata);
      #1;
      act_flags = {cpu_ack, cpu_err, dma_ack, dma_err, mem_rd, mem_wr, busy, cpu_stall};
      checkOutput($sformatf("vec%0d_flags", i),     32'(act_flags), 32'(vecs[i].flags));
      checkOutput($sformatf("vec%0d_cpu_rdata", i), cpu_rdata,      vecs[i].cpu_rdata);
      checkOutput($sformatf("vec%0d_dma_rdata", i), dma_rdata,      vecs[i].dma_rdata);
      checkOutput($sformatf("vec%0d_mem_addr", i),  mem_addr,       vecs[i].mem_addr);
      checkOutput($sformatf("vec%0d_mem_wdata", i), mem_wdata,      vecs[i].mem_wdata);
      stepCycle();
    end

    // Starvation: both ports request continuously; expect C,C,C,C,D repeating
    applyStimulus(1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0, 32'h11112222);
    grants = 0;
    cyc = 0;
    while ((grants < 10) && (cyc < 200)) begin
      #1;
      checkOutput($sformatf("starve_c%0d_strobe_excl", cyc), 32'(mem_rd & mem_wr), 32'd0);
      if (cpu_ack | dma_ack) begin
        checkOutput($sformatf("grant%0d_is_dma", grants), 32'(dma_ack), 32'((grants % 5) == 4));
        checkOutput($sformatf("grant%0d_single_ack", grants), 32'(cpu_ack & dma_ack), 32'd0);
        if (dma_ack) checkOutput($sformatf("grant%0d_stall_during_dma", grants), 32'(cpu_stall), 32'd1);
        grants++;
      end
      stepCycle();
      cyc++;
    end
    if (grants < 10) begin
      checks++;
      errors++;
      $display("[TB] FAIL starve_timeout: got %0d grants, expected 10", grants);
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    #1;
    checkOutput("starve_end_busy", 32'(busy), 32'd0);
    stepCycle();

    // Reset during the second ACCESS cycle of a DMA write, CPU waiting
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h80, 32'h55AA55AA, 32'h31415926);
    #1;
    checkOutput("rst_pre_mem_wr", 32'(mem_wr), 32'd0);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 32'h90, 32'h0, 1'b1, 1'b1, 32'h80, 32'h55AA55AA, 32'h31415926);
    #1;
    checkOutput("rst_acc1_mem_wr",    32'(mem_wr),    32'd1);
    checkOutput("rst_acc1_mem_rd",    32'(mem_rd),    32'd0);
    checkOutput("rst_acc1_mem_addr",  mem_addr,       32'h80);
    checkOutput("rst_acc1_mem_wdata", mem_wdata,      32'h55AA55AA);
    checkOutput("rst_acc1_cpu_stall", 32'(cpu_stall), 32'd1);
    stepCycle();
    #1;
    checkOutput("rst_acc2_mem_wr", 32'(mem_wr), 32'd1);
    reset = 1'b1;
    stepCycle();
    reset = 1'b0;
    #1;
    checkOutput("rst_after_mem_wr",   32'(mem_wr),  32'd0);
    checkOutput("rst_after_mem_rd",   32'(mem_rd),  32'd0);
    checkOutput("rst_after_busy",     32'(busy),    32'd0);
    checkOutput("rst_after_dma_ack",  32'(dma_ack), 32'd0);
    checkOutput("rst_after_cpu_ack",  32'(cpu_ack), 32'd0);
    checkOutput("rst_after_mem_addr", mem_addr,     32'd0);
    stepCycle();
    #1;
    checkOutput("rst_regrant_mem_rd",   32'(mem_rd), 32'd1);
    checkOutput("rst_regrant_mem_addr", mem_addr,    32'h90);
    stepCycle();
    stepCycle();
    #1;
    checkOutput("rst_regrant_cpu_ack",   32'(cpu_ack), 32'd1);
    checkOutput("rst_regrant_dma_ack",   32'(dma_ack), 32'd0);
    checkOutput("rst_regrant_cpu_rdata", cpu_rdata,    32'h31415926);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h80, 32'h55AA55AA, 32'h31415926);
    stepCycle();
    seen = 1'b0;
    for (int c = 0; (c < 10) && !seen; c++) begin
      #1;
      if (dma_ack) begin
        seen = 1'b1;
        checkOutput("rst_dma_later_err", 32'(dma_err), 32'd0);
      end
      stepCycle();
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL rst_dma_later_timeout: got no dma_ack, expected one within 10 cycles");
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    stepCycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
